// File: rtl/serial_subtract_seq.sv
// -----------------------------------------------------------------------------
// serial_subtract_seq
//
// Bit-serial N-bit subtractor computing (a - b - bin) mod 2^N with one 1-bit
// subtractor cell. Operands are captured on an accepted start, then shifted
// LSB-first through the cell for N cycles. The borrow is carried between
// cycles in a flop. The finished result is published in a single update,
// so diff/borrow never show partial values.
//
// Ports
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   start   : request a new operation (sampled only in IDLE)
//   a, b    : N-bit unsigned minuend / subtrahend (sampled with start)
//   bin     : borrow-in for word chaining (sampled with start)
//   busy    : high while in SHIFT or DONE
//   done    : one-cycle pulse while in DONE
//   diff    : N-bit result, held until the next completion
//   borrow  : final borrow-out, held with diff
// -----------------------------------------------------------------------------

// Generic WIDTH-bit subtractor cell: {bout, d} = a - b - bin.
module sub_cell #(
    parameter int WIDTH = 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic [WIDTH-1:0] d,
    output logic             bout
);
    // One extra bit holds the borrow: a negative result wraps into the top bit.
    logic [WIDTH:0] full_s;

    assign full_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, bin};
    assign d      = full_s[WIDTH-1:0];
    assign bout   = full_s[WIDTH];
endmodule

module serial_subtract_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] diff,
    output logic         borrow
);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t         state_q,  state_d;
    logic [N-1:0]   a_sh_q,   a_sh_d;
    logic [N-1:0]   b_sh_q,   b_sh_d;
    logic [N-1:0]   d_sh_q,   d_sh_d;
    logic           brw_q,    brw_d;
    logic [CW-1:0]  cnt_q,    cnt_d;
    logic [N-1:0]   diff_q,   diff_d;
    logic           borrow_q, borrow_d;
    logic           busy_q,   busy_d;
    logic           done_q,   done_d;

    logic           cell_d_s;
    logic           cell_bout_s;

    // Single-bit datapath: current LSBs plus the stored borrow.
    sub_cell #(
        .WIDTH (1)
    ) u_cell (
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .bin  (brw_q),
        .d    (cell_d_s),
        .bout (cell_bout_s)
    );

    // Next-state, datapath and registered-output decode.
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        brw_d    = brw_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    brw_d   = bin;
                    cnt_d   = {CW{1'b0}};
                    state_d = ST_SHIFT;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // Difference bits enter at the MSB, so after N shifts bit 0 is the LSB.
                d_sh_d = {cell_d_s, d_sh_q[N-1:1]};
                brw_d  = cell_bout_s;
                cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                if (cnt_q == LAST_BIT) begin
                    // Publish the full result in one update; no partial values leak out.
                    diff_d   = {cell_d_s, d_sh_q[N-1:1]};
                    borrow_d = cell_bout_s;
                    state_d  = ST_DONE;
                end else begin
                    state_d  = ST_SHIFT;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Status flags are registered copies of the next state's decode.
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= {N{1'b0}};
            b_sh_q   <= {N{1'b0}};
            d_sh_q   <= {N{1'b0}};
            brw_q    <= 1'b0;
            cnt_q    <= {CW{1'b0}};
            diff_q   <= {N{1'b0}};
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;
endmodule

// File: tb/tb_serial_subtract_seq.sv
// Directed bench for serial_subtract_seq (N=8) with hand-computed expectations.
module tb_serial_subtract_seq;
    localparam int N = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [N-1:0] diff;
    logic         borrow;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    // Expected held result from the last completed operation.
    logic [N-1:0] last_diff   = '0;
    logic         last_borrow = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    serial_subtract_seq #(.N(N)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .borrow (borrow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called #1 after a rising edge with the DUT idle. Runs one operation and
    // checks cycle-by-cycle timing, result hold and final result.
    // poke=1 drives start with different operands for every SHIFT/DONE edge.
    task automatic run_op(input string tag, input logic [N-1:0] ta, input logic [N-1:0] tb_,
                          input logic tbin, input logic [N-1:0] ed, input logic eb,
                          input bit poke);
        a = ta; b = tb_; bin = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = ~ta; b = ~tb_; bin = ~tbin;
        check({tag, ":busy0"}, busy, 1'b1);
        check({tag, ":done0"}, done, 1'b0);
        for (int i = 1; i <= N + 1; i++) begin
            if (poke) begin
                start = 1'b1; a = 8'hFF; b = 8'h01; bin = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            check({tag, ":busy"}, busy, (i <= N) ? 1'b1 : 1'b0);
            check({tag, ":done"}, done, (i == N) ? 1'b1 : 1'b0);
            if (i < N) begin
                check({tag, ":hold_diff"}, diff, last_diff);
                check({tag, ":hold_brw"}, borrow, last_borrow);
            end else begin
                check({tag, ":diff"}, diff, ed);
                check({tag, ":borrow"}, borrow, eb);
            end
        end
        start = 1'b0;
        last_diff = ed;
        last_borrow = eb;
    endtask

    // Bounded wait for a done pulse; returns the cycle stamp it was seen at.
    task automatic wait_done(input string tag, output int stamp);
        int c;
        c = 0;
        while (done !== 1'b1 && c < 40) begin
            @(posedge clk); #1;
            c++;
        end
        check({tag, ":seen"}, done, 1'b1);
        stamp = cyc;
    endtask

    initial begin
        int t1, t2, t3;
        rst_n = 1'b0; start = 1'b0; a = 8'd0; b = 8'd0; bin = 1'b0;
        #12;
        check("rst:busy", busy, 1'b0);
        check("rst:done", done, 1'b0);
        check("rst:diff", diff, 8'd0);
        check("rst:borrow", borrow, 1'b0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic",     8'd100, 8'd58, 1'b0, 8'd42,  1'b0, 1'b0);
        run_op("underflow", 8'd5,   8'd10, 1'b0, 8'd251, 1'b1, 1'b0);
        run_op("zero_bin",  8'd0,   8'd0,  1'b1, 8'd255, 1'b1, 1'b0);
        run_op("chain_lo",  8'h00,  8'h01, 1'b0, 8'hFF,  1'b1, 1'b0);
        run_op("chain_hi",  8'h12,  8'h00, 1'b1, 8'h11,  1'b0, 1'b0);
        run_op("max_min",   8'd255, 8'd0,  1'b0, 8'd255, 1'b0, 1'b0);
        run_op("poke",      8'd150, 8'd23, 1'b0, 8'd127, 1'b0, 1'b1);

        // Result hold with start low.
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            check("hold:diff", diff, 8'd127);
            check("hold:borrow", borrow, 1'b0);
            check("hold:done", done, 1'b0);
        end

        // start held high: one accepted operation every N+2 cycles.
        a = 8'd3; b = 8'd1; bin = 1'b0; start = 1'b1;
        wait_done("held1", t1);
        check("held1:diff", diff, 8'd2);
        @(posedge clk); #1;
        wait_done("held2", t2);
        @(posedge clk); #1;
        wait_done("held3", t3);
        check("held:period1", t2 - t1, N + 2);
        check("held:period2", t3 - t2, N + 2);
        start = 1'b0;
        for (int i = 0; i < 2 * (N + 2); i++) begin
            @(posedge clk); #1;
        end
        check("held:idle", busy, 1'b0);
        check("held:diff_end", diff, 8'd2);
        last_diff = 8'd2;
        last_borrow = 1'b0;

        // Reset during SHIFT cycle 4.
        a = 8'd77; b = 8'd11; bin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
        end
        check("mid:busy_pre", busy, 1'b1);
        #1 rst_n = 1'b0;
        #1;
        check("mid:busy", busy, 1'b0);
        check("mid:done", done, 1'b0);
        check("mid:diff", diff, 8'd0);
        check("mid:borrow", borrow, 1'b0);
        @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < N + 4; i++) begin
            @(posedge clk); #1;
            check("post_rst:done", done, 1'b0);
            check("post_rst:busy", busy, 1'b0);
        end
        last_diff = 8'd0;
        last_borrow = 1'b0;
        run_op("after_rst", 8'd200, 8'd199, 1'b0, 8'd1, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
